alu_reservation_station: RTL and testbench

- Issue-side producer for the ALU functional unit: buffers dispatched ALU micro-ops until both source operands are available, then issues at most one ready op per cycle.
- Issue bundle matches the functional unit's inputs: op, rs1, rs2, tags, rob_index, valid.
- Sits between rename/dispatch and the ALU; snoops the common data bus (CDB) for operand wakeup.

---
 rtl/rs_pkg.sv | 51 +++++
 rtl/rs_pick_lowest.sv | 23 ++
 rtl/alu_reservation_station.sv | 160 ++++++++++++++++
 tb/tb_alu_reservation_station.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rs_pkg.sv
// Shared types and constants for the ALU reservation station.
// Also the ALU op encodings used by the functional unit.
package rs_pkg;

    localparam int RS_REG_SIZE  = 32;
    localparam int RS_NUM_TAGS  = 64;
    localparam int RS_TAG_W     = $clog2(RS_NUM_TAGS);
    localparam int RS_ROB_SIZE  = 64;
    localparam int RS_ROB_W     = $clog2(RS_ROB_SIZE);
    localparam int RS_DEPTH_DEF = 8;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_XOR = 4'b1000;
    localparam logic [3:0] ALU_AND = 4'b1110;
    localparam logic [3:0] ALU_SLL = 4'b0010;
    localparam logic [3:0] ALU_SRL = 4'b1010;
    localparam logic [3:0] ALU_SRA = 4'b1011;

    typedef struct packed {
        logic [RS_REG_SIZE-1:0] val;
        logic [RS_TAG_W-1:0]    tag;
        logic                   rdy;
    } rs_src_t;

    typedef struct packed {
        logic                   valid;
        logic [3:0]             op;
        rs_src_t                src1;
        rs_src_t                src2;
        logic [RS_TAG_W-1:0]    rd_tag;
        logic [RS_ROB_W-1:0]    rob_index;
    } rs_entry_t;

    // A waiting source captures a matching CDB broadcast.
    function automatic rs_src_t rs_wake(
        rs_src_t                s,
        logic                   cv,
        logic [RS_TAG_W-1:0]    ct,
        logic [RS_REG_SIZE-1:0] cval
    );
        rs_src_t r;
        r = s;
        if (cv && !s.rdy && (s.tag == ct)) begin
            r.val = cval;
            r.rdy = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rs_pick_lowest.sv
// Priority encoder: reports whether any request bit is set
// and the index of the lowest one.
module rs_pick_lowest #(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    output logic         found,
    output logic [W-1:0] idx
);

    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                found = 1'b1;
                idx   = W'(i);
            end
        end
    end

endmodule

// File: rtl/alu_reservation_station.sv
// ALU reservation station: holds dispatched ops until both operands
// are ready, snoops the CDB, and issues the lowest ready entry.
module alu_reservation_station
    import rs_pkg::*;
#(
    parameter int REG_SIZE      = RS_REG_SIZE,
    parameter int NUM_TAGS      = RS_NUM_TAGS,
    parameter int NUM_TAGS_LOG2 = $clog2(NUM_TAGS),
    parameter int ROB_SIZE      = RS_ROB_SIZE,
    parameter int ROB_SIZE_LOG2 = $clog2(ROB_SIZE),
    parameter int RS_DEPTH      = RS_DEPTH_DEF,
    parameter int IDX_W         = $clog2(RS_DEPTH),
    parameter int OCC_W         = IDX_W + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     disp_valid,
    output logic                     disp_ready,
    input  logic [3:0]               disp_op,
    input  logic [REG_SIZE-1:0]      disp_src1_val,
    input  logic [REG_SIZE-1:0]      disp_src2_val,
    input  logic [NUM_TAGS_LOG2-1:0] disp_src1_tag,
    input  logic [NUM_TAGS_LOG2-1:0] disp_src2_tag,
    input  logic                     disp_src1_rdy,
    input  logic                     disp_src2_rdy,
    input  logic [NUM_TAGS_LOG2-1:0] disp_rd_tag,
    input  logic [ROB_SIZE_LOG2-1:0] disp_rob_index,
    input  logic                     cdb_valid,
    input  logic [NUM_TAGS_LOG2-1:0] cdb_tag,
    input  logic [REG_SIZE-1:0]      cdb_value,
    output logic                     iss_valid,
    output logic [3:0]               iss_op,
    output logic [REG_SIZE-1:0]      iss_rs1,
    output logic [REG_SIZE-1:0]      iss_rs2,
    output logic [NUM_TAGS_LOG2-1:0] iss_tag,
    output logic [ROB_SIZE_LOG2-1:0] iss_rob_index,
    output logic [OCC_W-1:0]         occupancy
);

    rs_entry_t            entries_q [RS_DEPTH];
    rs_entry_t            entries_d [RS_DEPTH];
    logic [OCC_W-1:0]     occ_q;
    logic [OCC_W-1:0]     occ_d;

    logic [RS_DEPTH-1:0]  free_vec;
    logic [RS_DEPTH-1:0]  rdy_vec;
    logic                 free_found;
    logic                 sel_found;
    logic [IDX_W-1:0]     free_idx;
    logic [IDX_W-1:0]     sel_idx;
    logic                 do_disp;
    rs_src_t              in_src1;
    rs_src_t              in_src2;
    rs_entry_t            new_entry;

    always_comb begin
        free_vec = '0;
        rdy_vec  = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            free_vec[i] = !entries_q[i].valid;
            rdy_vec[i]  = entries_q[i].valid
                        & entries_q[i].src1.rdy
                        & entries_q[i].src2.rdy;
        end
    end

    rs_pick_lowest #(.N(RS_DEPTH), .W(IDX_W)) u_pick_free (
        .req   (free_vec),
        .found (free_found),
        .idx   (free_idx)
    );

    rs_pick_lowest #(.N(RS_DEPTH), .W(IDX_W)) u_pick_ready (
        .req   (rdy_vec),
        .found (sel_found),
        .idx   (sel_idx)
    );

    assign disp_ready = (occ_q != OCC_W'(RS_DEPTH));
    assign occupancy  = occ_q;
    assign do_disp    = disp_valid & disp_ready & free_found & !flush;

    // Incoming sources can be satisfied by the broadcast on the same edge.
    always_comb begin
        in_src1     = '0;
        in_src2     = '0;
        new_entry   = '0;
        in_src1.val = disp_src1_val;
        in_src1.tag = disp_src1_tag;
        in_src1.rdy = disp_src1_rdy;
        in_src2.val = disp_src2_val;
        in_src2.tag = disp_src2_tag;
        in_src2.rdy = disp_src2_rdy;
        new_entry.valid     = 1'b1;
        new_entry.op        = disp_op;
        new_entry.src1      = rs_wake(in_src1, cdb_valid, cdb_tag, cdb_value);
        new_entry.src2      = rs_wake(in_src2, cdb_valid, cdb_tag, cdb_value);
        new_entry.rd_tag    = disp_rd_tag;
        new_entry.rob_index = disp_rob_index;
    end

    always_comb begin
        entries_d = entries_q;
        occ_d     = occ_q;
        if (flush) begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                entries_d[i].valid = 1'b0;
            end
            occ_d = '0;
        end else begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                if (entries_q[i].valid) begin
                    entries_d[i].src1 = rs_wake(entries_q[i].src1,
                                                cdb_valid, cdb_tag, cdb_value);
                    entries_d[i].src2 = rs_wake(entries_q[i].src2,
                                                cdb_valid, cdb_tag, cdb_value);
                end
            end
            // Free slot comes from pre-edge state, so it never aliases sel_idx.
            if (sel_found) begin
                entries_d[sel_idx].valid = 1'b0;
            end
            if (do_disp) begin
                entries_d[free_idx] = new_entry;
            end
            occ_d = occ_q + OCC_W'(do_disp) - OCC_W'(sel_found);
        end
    end

    always_comb begin
        iss_valid     = 1'b0;
        iss_op        = '0;
        iss_rs1       = '0;
        iss_rs2       = '0;
        iss_tag       = '0;
        iss_rob_index = '0;
        if (sel_found) begin
            iss_valid     = 1'b1;
            iss_op        = entries_q[sel_idx].op;
            iss_rs1       = entries_q[sel_idx].src1.val;
            iss_rs2       = entries_q[sel_idx].src2.val;
            iss_tag       = entries_q[sel_idx].rd_tag;
            iss_rob_index = entries_q[sel_idx].rob_index;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                entries_q[i] <= '0;
            end
            occ_q <= '0;
        end else begin
            entries_q <= entries_d;
            occ_q     <= occ_d;
        end
    end

endmodule

// File: tb/tb_alu_reservation_station.sv
// Randomized and directed bench for alu_reservation_station,
// checked against a slot-array reference model.
module tb_alu_reservation_station;
    import rs_pkg::*;

    localparam int RW = 32;
    localparam int TW = 6;
    localparam int BW = 6;
    localparam int D  = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          flush = 1'b0;
    logic          disp_valid = 1'b0;
    logic          disp_ready;
    logic [3:0]    disp_op = '0;
    logic [RW-1:0] disp_src1_val = '0;
    logic [RW-1:0] disp_src2_val = '0;
    logic [TW-1:0] disp_src1_tag = '0;
    logic [TW-1:0] disp_src2_tag = '0;
    logic          disp_src1_rdy = 1'b0;
    logic          disp_src2_rdy = 1'b0;
    logic [TW-1:0] disp_rd_tag = '0;
    logic [BW-1:0] disp_rob_index = '0;
    logic          cdb_valid = 1'b0;
    logic [TW-1:0] cdb_tag = '0;
    logic [RW-1:0] cdb_value = '0;
    logic          iss_valid;
    logic [3:0]    iss_op;
    logic [RW-1:0] iss_rs1;
    logic [RW-1:0] iss_rs2;
    logic [TW-1:0] iss_tag;
    logic [BW-1:0] iss_rob_index;
    logic [3:0]    occupancy;

    alu_reservation_station dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .disp_valid     (disp_valid),
        .disp_ready     (disp_ready),
        .disp_op        (disp_op),
        .disp_src1_val  (disp_src1_val),
        .disp_src2_val  (disp_src2_val),
        .disp_src1_tag  (disp_src1_tag),
        .disp_src2_tag  (disp_src2_tag),
        .disp_src1_rdy  (disp_src1_rdy),
        .disp_src2_rdy  (disp_src2_rdy),
        .disp_rd_tag    (disp_rd_tag),
        .disp_rob_index (disp_rob_index),
        .cdb_valid      (cdb_valid),
        .cdb_tag        (cdb_tag),
        .cdb_value      (cdb_value),
        .iss_valid      (iss_valid),
        .iss_op         (iss_op),
        .iss_rs1        (iss_rs1),
        .iss_rs2        (iss_rs2),
        .iss_tag        (iss_tag),
        .iss_rob_index  (iss_rob_index),
        .occupancy      (occupancy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          v;
        bit [3:0]    op;
        bit [RW-1:0] val1;
        bit [RW-1:0] val2;
        bit [TW-1:0] t1;
        bit [TW-1:0] t2;
        bit          r1;
        bit          r2;
        bit [TW-1:0] rd;
        bit [BW-1:0] rob;
    } slot_t;

    slot_t m [D];
    int checks = 0;
    int failures = 0;
    logic [3:0] ops [7];

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int m_pick();
        for (int i = 0; i < D; i++)
            if (m[i].v && m[i].r1 && m[i].r2) return i;
        return -1;
    endfunction

    function automatic int m_count();
        int n = 0;
        for (int i = 0; i < D; i++) if (m[i].v) n++;
        return n;
    endfunction

    function automatic void m_clear();
        for (int i = 0; i < D; i++) m[i].v = 1'b0;
    endfunction

    task automatic check_outputs();
        int s;
        slot_t e;
        s = m_pick();
        e = '{default: 0};
        if (s >= 0) e = m[s];
        chk("iss_valid", 64'(iss_valid), 64'(s >= 0));
        chk("iss_op", 64'(iss_op), 64'(e.op));
        chk("iss_rs1", 64'(iss_rs1), 64'(e.val1));
        chk("iss_rs2", 64'(iss_rs2), 64'(e.val2));
        chk("iss_tag", 64'(iss_tag), 64'(e.rd));
        chk("iss_rob", 64'(iss_rob_index), 64'(e.rob));
        chk("occupancy", 64'(occupancy), 64'(m_count()));
        chk("disp_ready", 64'(disp_ready), 64'(m_count() != D));
    endtask

    // One clock edge of the behavioural model, from the current inputs.
    task automatic model_edge();
        int s, n, f;
        slot_t ne;
        if (!rst || flush) begin
            m_clear();
            return;
        end
        s = m_pick();
        n = m_count();
        f = -1;
        for (int i = D - 1; i >= 0; i--) if (!m[i].v) f = i;
        if (cdb_valid) begin
            for (int i = 0; i < D; i++) begin
                if (m[i].v && !m[i].r1 && m[i].t1 == cdb_tag) begin
                    m[i].r1 = 1'b1;
                    m[i].val1 = cdb_value;
                end
                if (m[i].v && !m[i].r2 && m[i].t2 == cdb_tag) begin
                    m[i].r2 = 1'b1;
                    m[i].val2 = cdb_value;
                end
            end
        end
        if (s >= 0) m[s].v = 1'b0;
        if (disp_valid && n < D && f >= 0) begin
            ne.v = 1'b1;
            ne.op = disp_op;
            ne.val1 = disp_src1_val;
            ne.val2 = disp_src2_val;
            ne.t1 = disp_src1_tag;
            ne.t2 = disp_src2_tag;
            ne.r1 = disp_src1_rdy;
            ne.r2 = disp_src2_rdy;
            ne.rd = disp_rd_tag;
            ne.rob = disp_rob_index;
            if (cdb_valid && !ne.r1 && ne.t1 == cdb_tag) begin
                ne.r1 = 1'b1;
                ne.val1 = cdb_value;
            end
            if (cdb_valid && !ne.r2 && ne.t2 == cdb_tag) begin
                ne.r2 = 1'b1;
                ne.val2 = cdb_value;
            end
            m[f] = ne;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic quiet();
        disp_valid = 1'b0;
        cdb_valid = 1'b0;
        flush = 1'b0;
    endtask

    task automatic set_disp(
        input logic [3:0] op,
        input logic [RW-1:0] v1, input logic [TW-1:0] t1, input logic r1,
        input logic [RW-1:0] v2, input logic [TW-1:0] t2, input logic r2,
        input logic [TW-1:0] rd, input logic [BW-1:0] rob
    );
        disp_valid = 1'b1;
        disp_op = op;
        disp_src1_val = v1;
        disp_src1_tag = t1;
        disp_src1_rdy = r1;
        disp_src2_val = v2;
        disp_src2_tag = t2;
        disp_src2_rdy = r2;
        disp_rd_tag = rd;
        disp_rob_index = rob;
    endtask

    task automatic set_cdb(input logic [TW-1:0] t, input logic [RW-1:0] v);
        cdb_valid = 1'b1;
        cdb_tag = t;
        cdb_value = v;
    endtask

    initial begin
        ops = '{ALU_ADD, ALU_SUB, ALU_XOR, ALU_AND,
                ALU_SLL, ALU_SRL, ALU_SRA};
        m_clear();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        check_outputs();

        // Both operands ready: issue one cycle after dispatch.
        set_disp(ALU_ADD, 5, 0, 1, 7, 0, 1, 3, 9);
        tick();
        chk("add_valid", 64'(iss_valid), 1);
        chk("add_rs1", 64'(iss_rs1), 5);
        chk("add_rob", 64'(iss_rob_index), 9);
        quiet();
        tick();
        chk("add_drain", 64'(occupancy), 0);

        // Wait on tag 12; tag 13 must not wake it.
        set_disp(ALU_SUB, 0, 12, 0, 1, 0, 1, 4, 10);
        tick();
        quiet();
        set_cdb(13, 32'h55);
        tick();
        chk("tag13_nowake", 64'(iss_valid), 0);
        set_cdb(12, 32'h20);
        tick();
        chk("wake_rs1", 64'(iss_rs1), 32'h20);
        quiet();
        tick();

        // Same-edge bypass from the CDB at dispatch.
        set_disp(ALU_XOR, 0, 4, 0, 3, 0, 1, 5, 11);
        set_cdb(4, 32'hAA);
        tick();
        chk("bypass_rs1", 64'(iss_rs1), 32'hAA);
        quiet();
        tick();

        // Fill all entries waiting on tag 20, then drop one extra.
        for (int i = 0; i < D; i++) begin
            set_disp(ALU_AND, 0, 20, 0, i, 0, 1, 6, i);
            tick();
        end
        chk("full_occ", 64'(occupancy), 8);
        chk("full_ready", 64'(disp_ready), 0);
        set_disp(ALU_AND, 0, 20, 0, 0, 0, 1, 6, 63);
        tick();
        chk("drop_occ", 64'(occupancy), 8);
        quiet();
        set_cdb(20, 32'h1234);
        tick();
        quiet();
        for (int i = 0; i < D; i++) begin
            chk("order_rob", 64'(iss_rob_index), 64'(i));
            tick();
        end
        chk("drain_occ", 64'(occupancy), 0);

        // Entries 2 and 5 wake together; others wait forever on 31.
        for (int i = 0; i < 6; i++) begin
            set_disp(ALU_SLL, 0, (i == 2 || i == 5) ? 6'd25 : 6'd31, 0,
                     1, 0, 1, 7, 10 + i);
            tick();
        end
        quiet();
        set_cdb(25, 32'h77);
        tick();
        chk("first_of_two", 64'(iss_rob_index), 12);
        quiet();
        set_disp(ALU_SRL, 0, 31, 0, 2, 0, 1, 8, 40);
        tick();
        chk("second_of_two", 64'(iss_rob_index), 15);
        chk("disp_iss_occ", 64'(occupancy), 6);

        // Flush with a concurrent dispatch.
        set_disp(ALU_SRA, 1, 0, 1, 2, 0, 1, 9, 41);
        flush = 1'b1;
        tick();
        chk("flush_occ", 64'(occupancy), 0);
        chk("flush_iss", 64'(iss_valid), 0);
        quiet();

        // Asynchronous reset between edges.
        set_disp(ALU_ADD, 1, 0, 1, 2, 0, 1, 9, 42);
        tick();
        quiet();
        chk("pre_rst_iss", 64'(iss_valid), 1);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_iss", 64'(iss_valid), 0);
        chk("async_rst_occ", 64'(occupancy), 0);
        chk("async_rst_rdy", 64'(disp_ready), 1);
        m_clear();
        @(negedge clk);
        rst = 1'b1;
        check_outputs();

        for (int c = 0; c < 600; c++) begin
            disp_valid = ($urandom_range(0, 9) < 7);
            disp_op = ops[$urandom_range(0, 6)];
            disp_src1_val = $urandom;
            disp_src2_val = $urandom;
            disp_src1_tag = TW'($urandom_range(0, 7));
            disp_src2_tag = TW'($urandom_range(0, 7));
            disp_src1_rdy = $urandom_range(0, 1) == 1;
            disp_src2_rdy = $urandom_range(0, 1) == 1;
            disp_rd_tag = TW'($urandom);
            disp_rob_index = BW'($urandom);
            cdb_valid = $urandom_range(0, 1) == 1;
            cdb_tag = TW'($urandom_range(0, 7));
            cdb_value = $urandom;
            flush = ($urandom_range(0, 49) == 0);
            tick();
        end
        quiet();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
